// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, bit timing and parity-mode encoding.
// The receiver imports the same package, so both ends agree on framing.
package uart_pkg;

  // FSM state encoding (3-bit, kept as plain constants for legacy tools)
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // 16x oversampling: one bit lasts this many enable ticks
  localparam int         TICKS_PER_BIT = 16;
  localparam logic [3:0] TICK_LAST     = 4'(TICKS_PER_BIT - 1);

  // odd_r_even_parity encoding: 1 makes the total count of ones even,
  // 0 makes it odd
  localparam logic PAR_EVEN_TOTAL = 1'b1;
  localparam logic PAR_ODD_TOTAL  = 1'b0;

  // Parity bit for a payload; zero-extension does not change the XOR reduction
  function automatic logic parity_bit(input logic [31:0] data, input logic mode);
    logic p;
    if (mode == PAR_EVEN_TOTAL) begin
      p = ^data;
    end else begin
      p = ~^data;
    end
    return p;
  endfunction

endpackage

// File: rtl/transmitter.sv
// UART transmitter: start bit, LSB-first payload, optional parity, 1 or 2
// stop bits. Bit timing from an external 16x enable; start/busy/done handshake.
module transmitter
  import uart_pkg::*;
#(
  parameter int data_width = 8,
  parameter int stop_bits  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_tick,
  input  logic                  tx_start,
  input  logic [data_width-1:0] data_in,
  input  logic                  parity_en,
  input  logic                  odd_r_even_parity,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int              BCW       = $clog2(data_width);
  localparam logic [BCW-1:0]  BIT_LAST  = BCW'(data_width - 1);
  // Anything other than 2 stop bits behaves as 1
  localparam logic            STOP_LAST = (stop_bits == 2) ? 1'b1 : 1'b0;

  logic [2:0]            state_r;
  logic [3:0]            tick_cnt_r;
  logic [BCW-1:0]        bit_cnt_r;
  logic                  stop_cnt_r;
  logic [data_width-1:0] shift_r;
  logic                  par_en_r;
  logic                  par_bit_r;
  logic                  bit_end_s;

  // A bit period closes on the tick that finds the tick counter at its last value
  assign bit_end_s = tx_tick && (tick_cnt_r == TICK_LAST);

  // Frame FSM and datapath; tx, busy and done are all driven from flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      tick_cnt_r <= 4'd0;
      bit_cnt_r  <= '0;
      stop_cnt_r <= 1'b0;
      shift_r    <= '0;
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;

      // Tick counter runs only inside a frame and reloads explicitly after 15
      if ((state_r != IDLE) && tx_tick) begin
        tick_cnt_r <= bit_end_s ? 4'd0 : (tick_cnt_r + 4'd1);
      end else begin
        tick_cnt_r <= tick_cnt_r;
      end

      case (state_r)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (tx_start && !busy) begin
            // A tick on this same edge is not counted for the new frame
            shift_r    <= data_in;
            par_en_r   <= parity_en;
            par_bit_r  <= parity_bit(32'(data_in), odd_r_even_parity);
            tick_cnt_r <= 4'd0;
            bit_cnt_r  <= '0;
            stop_cnt_r <= 1'b0;
            state_r    <= START;
            busy       <= 1'b1;
            tx         <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          if (bit_end_s) begin
            state_r   <= DATA;
            bit_cnt_r <= '0;
            tx        <= shift_r[0];
          end else begin
            state_r <= START;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            shift_r <= shift_r >> 1;
            if (bit_cnt_r == BIT_LAST) begin
              if (par_en_r) begin
                state_r <= PARITY;
                tx      <= par_bit_r;
              end else begin
                state_r    <= STOP;
                stop_cnt_r <= 1'b0;
                tx         <= 1'b1;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + BCW'(1);
              tx        <= shift_r[1];
            end
          end else begin
            state_r <= DATA;
          end
        end
        PARITY: begin
          if (bit_end_s) begin
            state_r    <= STOP;
            stop_cnt_r <= 1'b0;
            tx         <= 1'b1;
          end else begin
            state_r <= PARITY;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (bit_end_s) begin
            if (stop_cnt_r == STOP_LAST) begin
              state_r <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              stop_cnt_r <= 1'b1;
            end
          end else begin
            state_r <= STOP;
          end
        end
        default: begin
          // Unreachable encoding: recover to a quiet idle line
          state_r    <= IDLE;
          tick_cnt_r <= 4'd0;
          bit_cnt_r  <= '0;
          stop_cnt_r <= 1'b0;
          tx         <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// Self-checking bench for transmitter: a frame-level reference model checks
// tx/busy/done every cycle, a mid-bit sampler decodes each frame, plus
// table-driven and hand-written multi-cycle sequences.
module tb_transmitter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_tick = 1'b0;
  logic       tx_start = 1'b0;
  logic       start2 = 1'b0;
  logic       parity_en = 1'b0;
  logic       odd_r_even_parity = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx, busy, done;
  logic       tx2, busy2, done2;

  int checks = 0;
  int errors = 0;

  transmitter #(.data_width(8), .stop_bits(1)) dut (
    .clk(clk), .rst(rst), .tx_tick(tx_tick), .tx_start(tx_start),
    .data_in(data_in), .parity_en(parity_en),
    .odd_r_even_parity(odd_r_even_parity),
    .tx(tx), .busy(busy), .done(done)
  );

  transmitter #(.data_width(8), .stop_bits(2)) dut2 (
    .clk(clk), .rst(rst), .tx_tick(tx_tick), .tx_start(start2),
    .data_in(data_in), .parity_en(parity_en),
    .odd_r_even_parity(odd_r_even_parity),
    .tx(tx2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  // 16x enable: one clk wide, every 4 clocks
  initial begin
    int tc;
    tc = 0;
    forever begin
      @(posedge clk);
      #1;
      tc = (tc + 1) % 4;
      tx_tick = (tc == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Parity from the rule: make the total number of ones even (mode 1) or odd (mode 0)
  function automatic logic ref_par(input logic [7:0] d, input logic mode);
    int ones;
    ones = $countones(d);
    return mode ? ((ones % 2) == 1) : ((ones % 2) == 0);
  endfunction

  // ---------------- frame-level reference model ----------------
  logic m_active;
  int   m_n, m_total, m_len;
  logic m_bits[16];
  logic e_tx, e_busy, e_done;
  logic s_rst, s_start, s_tick, s_pe, s_odd;
  logic [7:0] s_data;
  int   tick_total = 0;
  int   acc_tick = 0;
  int   done_tick = 0;
  int   done_count = 0;
  logic rx_cap[16];
  int   cap_len = 0;

  initial begin
    m_active = 1'b0; m_n = 0; m_total = 0; m_len = 0;
    e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    forever begin
      @(posedge clk);
      s_rst = rst; s_start = tx_start; s_tick = tx_tick;
      s_data = data_in; s_pe = parity_en; s_odd = odd_r_even_parity;
      @(negedge clk);
      if (s_tick) tick_total++;
      if (!rst || !s_rst) begin
        m_active = 1'b0; e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      end else if (!m_active) begin
        e_done = 1'b0;
        if (s_start) begin
          m_bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) m_bits[1+i] = s_data[i];
          m_len = 9;
          if (s_pe) begin
            m_bits[9] = ref_par(s_data, s_odd);
            m_len = 10;
          end
          m_bits[m_len] = 1'b1;
          m_len = m_len + 1;
          m_total = 16 * m_len;
          m_active = 1'b1; m_n = 0;
          e_tx = 1'b0; e_busy = 1'b1;
          acc_tick = tick_total;
          cap_len = m_len;
          for (int k = 0; k < 16; k++) rx_cap[k] = 1'bx;
        end else begin
          e_tx = 1'b1; e_busy = 1'b0;
        end
      end else begin
        e_done = 1'b0; e_busy = 1'b1;
        if (s_tick) m_n++;
        if (m_n == m_total) begin
          m_active = 1'b0; e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b1;
        end else begin
          e_tx = m_bits[m_n / 16];
          if (s_tick && (m_n % 16) == 8) rx_cap[m_n / 16] = tx;
        end
      end
      if (done) begin
        done_count++;
        done_tick = tick_total;
      end
      check("tx_line", tx, e_tx);
      check("busy", busy, e_busy);
      check("done", done, e_done);
    end
  end

  // ---------------- helpers ----------------
  task automatic nwait();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      nwait();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic odd);
    @(posedge clk); #1;
    data_in = d; parity_en = pe; odd_r_even_parity = odd; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
  endtask

  task automatic decode(output logic [7:0] d, output logic p, output logic st, output logic sb);
    st = rx_cap[0];
    for (int i = 0; i < 8; i++) d[i] = rx_cap[1+i];
    p  = (cap_len == 11) ? rx_cap[9] : 1'b0;
    sb = rx_cap[cap_len-1];
  endtask

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       odd;
    logic       exp_par;
    int         exp_ticks;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [7:0] rd;
    logic rp, rst_b, rsb;
    int dc, t0, n, last_low;
    logic [7:0] rnd_d;
    logic rnd_pe, rnd_odd;

    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 160};
    tbl[1] = '{8'h07, 1'b1, 1'b1, 1'b1, 176};
    tbl[2] = '{8'h07, 1'b1, 1'b0, 1'b0, 176};
    tbl[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 160};
    tbl[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 176};
    tbl[5] = '{8'hFF, 1'b1, 1'b1, 1'b0, 176};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tx2", tx2, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) nwait();

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].d, tbl[i].pe, tbl[i].odd);
      wait_done(1000);
      check("frame_ticks", 32'(done_tick - acc_tick), 32'(tbl[i].exp_ticks));
      decode(rd, rp, rst_b, rsb);
      check("rx_start", rst_b, 1'b0);
      check("rx_data", rd, tbl[i].d);
      check("rx_stop", rsb, 1'b1);
      if (tbl[i].pe) check("rx_parity", rp, tbl[i].exp_par);
    end

    // Reset in the middle of the data bits
    dc = done_count;
    send(8'hA5, 1'b0, 1'b0);
    repeat (150) nwait();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    repeat (10) nwait();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (800) nwait();
    check("midrst_no_done", 32'(done_count - dc), 32'd0);

    // tx_start pulsed mid-frame is ignored
    dc = done_count;
    send(8'hA5, 1'b0, 1'b0);
    repeat (200) nwait();
    @(posedge clk); #1;
    data_in = 8'hFF; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    wait_done(1000);
    decode(rd, rp, rst_b, rsb);
    check("ignore_data", rd, 8'hA5);
    repeat (800) nwait();
    check("ignore_one_done", 32'(done_count - dc), 32'd1);

    // Back-to-back with tx_start held high
    dc = done_count;
    @(posedge clk); #1;
    data_in = 8'h3C; parity_en = 1'b0; tx_start = 1'b1;
    @(posedge clk); #1;
    data_in = 8'hC3;
    wait_done(1000);
    decode(rd, rp, rst_b, rsb);
    check("b2b_first", rd, 8'h3C);
    wait_done(1000);
    tx_start = 1'b0;
    decode(rd, rp, rst_b, rsb);
    check("b2b_second", rd, 8'hC3);
    check("b2b_tick_len", 32'(done_tick - acc_tick), 32'd160);
    repeat (20) nwait();
    check("b2b_two_done", 32'(done_count - dc), 32'd2);

    // Randomized frames against the reference model
    for (int i = 0; i < 20; i++) begin
      rnd_d   = 8'($urandom_range(0, 255));
      rnd_pe  = 1'($urandom_range(0, 1));
      rnd_odd = 1'($urandom_range(0, 1));
      send(rnd_d, rnd_pe, rnd_odd);
      wait_done(1000);
      decode(rd, rp, rst_b, rsb);
      check("rnd_data", rd, rnd_d);
      if (rnd_pe) check("rnd_parity", rp, ref_par(rnd_d, rnd_odd));
    end

    // Two stop bits on the second instance
    @(posedge clk); #1;
    data_in = 8'h00; parity_en = 1'b0; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    nwait();
    check("sb2_busy", busy2, 1'b1);
    t0 = tick_total;
    n = 0;
    last_low = -1;
    for (int i = 0; i < 1500; i++) begin
      nwait();
      n = tick_total - t0;
      if (tx2 == 1'b0) last_low = n;
      if (done2) break;
    end
    check("sb2_done", done2, 1'b1);
    check("sb2_ticks", 32'(n), 32'd176);
    check("sb2_stop_high", 32'(last_low), 32'd143);
    check("sb2_tx_idle", tx2, 1'b1);
    nwait();
    check("sb2_done_pulse", done2, 1'b0);

    repeat (5) nwait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
